// File: rtl/car_request_conditioner_pkg.sv
// Shared constants for the car request conditioner: lane indices and timing defaults
// derived from the 50 MHz divider constant used by the intersection controller.
package car_request_conditioner_pkg;

  localparam int NUM_LANES = 2;
  localparam int LANE_N    = 0;
  localparam int LANE_E    = 1;

  // Same terminal count as the controller's 1 Hz divider.
  localparam logic [31:0] CNT_MAX = 32'd49_999_999;

  // 20 ms debounce and 60 s stuck timeout at 50 MHz.
  localparam int          DEB_CYCLES_DEF   = int'((CNT_MAX + 32'd1) / 32'd50);
  localparam logic [31:0] STUCK_CYCLES_DEF = (CNT_MAX + 32'd1) * 32'd60;

endpackage

// File: rtl/car_request_conditioner_lane_debouncer.sv
// One sensor lane: two-flop synchroniser, stable-count debouncer, debounced level
// and a registered rising-edge pulse.
module lane_debouncer #(
  parameter int DEB_CYCLES = 4
) (
  input  logic CLOCK_50,
  input  logic rst_n,
  input  logic sw_async,
  output logic lvl,
  output logic rise
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sw_meta;
  logic             sw_sync;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= 1'b0;
      sw_sync <= 1'b0;
      cnt     <= '0;
      lvl     <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sw_meta <= sw_async;
      sw_sync <= sw_meta;
      rise    <= 1'b0;
      if (sw_sync == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Level flips together with the edge pulse so RISE marks the first high cycle.
        lvl  <= sw_sync;
        rise <= sw_sync;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/car_request_conditioner.sv
// Per-lane sensor conditioning feeding the controller's car-present inputs.
// Optional stuck-sensor detection is compiled in with STUCK_DETECT_EN.
module car_request_conditioner
  import car_request_conditioner_pkg::*;
#(
  parameter int          DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter logic [31:0] STUCK_CYCLES = STUCK_CYCLES_DEF
) (
  input  logic                 CLOCK_50,
  input  logic [0:0]           KEY,
  input  logic [NUM_LANES-1:0] SW,
  input  logic [NUM_LANES-1:0] SERVE,
  output logic [NUM_LANES-1:0] LVL,
  output logic [NUM_LANES-1:0] RISE,
  output logic [NUM_LANES-1:0] REQ,
  output logic [NUM_LANES-1:0] STUCK
);

  logic rst_n;
  assign rst_n = KEY[0];

  if (DEB_CYCLES < 2 || STUCK_CYCLES == 32'd0) begin : g_bad_params
    $error("car_request_conditioner: DEB_CYCLES must be >= 2 and STUCK_CYCLES nonzero");
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    lane_debouncer #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .CLOCK_50(CLOCK_50),
      .rst_n   (rst_n),
      .sw_async(SW[gi]),
      .lvl     (LVL[gi]),
      .rise    (RISE[gi])
    );
  end

`ifdef STUCK_DETECT_EN
  logic [31:0]          stuck_cnt     [NUM_LANES];
  logic [31:0]          stuck_cnt_nxt [NUM_LANES];
  logic [NUM_LANES-1:0] stuck_nxt;

  always_comb begin
    stuck_nxt = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      stuck_cnt_nxt[i] = 32'd0;
      if (LVL[i]) begin
        stuck_cnt_nxt[i] = (stuck_cnt[i] == STUCK_CYCLES) ? stuck_cnt[i] : stuck_cnt[i] + 32'd1;
      end
      stuck_nxt[i] = (stuck_cnt_nxt[i] == STUCK_CYCLES);
    end
  end

  // A stuck lane never requests service, even on a fresh rising edge.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LANES; i++) stuck_cnt[i] <= 32'd0;
      STUCK <= '0;
      REQ   <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) stuck_cnt[i] <= stuck_cnt_nxt[i];
      STUCK <= stuck_nxt;
      REQ   <= (RISE | (REQ & ~SERVE)) & ~STUCK;
    end
  end
`else
  assign STUCK = '0;

  // Set has priority over SERVE so a car arriving on the green edge is not lost.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      REQ <= '0;
    end else begin
      REQ <= RISE | (REQ & ~SERVE);
    end
  end
`endif

endmodule

// File: doc/car_request_conditioner.md
Name: car_request_conditioner

Overview:
- Upstream stage of the intersection controller: turns the raw vehicle-sensor switches into clean, latched per-lane requests.
- Per lane: synchronise, debounce, detect arrival edges, hold a request until the controller signals that the lane was served.
- REQ[1:0] drives the controller's car-present inputs (bit0 = North, bit1 = East).

Parameters:
- DEB_CYCLES, 1000000, consecutive stable cycles required before the debounced level changes (20 ms at 50 MHz); must be >= 2.
- STUCK_CYCLES, 32'd3000000000, continuous debounced-high cycles before a lane is flagged stuck (60 s); used only with STUCK_DETECT_EN.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz
- KEY  input  1  KEY[0] is the reset: asynchronous, active-low
- SW  input  2  raw asynchronous sensor switches; bit0 North, bit1 East
- SERVE  input  2  one-cycle pulse per lane from the controller when that lane enters green
- LVL  output  2  debounced sensor level
- RISE  output  2  one-cycle pulse on each debounced 0->1 transition
- REQ  output  2  latched request, to the controller
- STUCK  output  2  stuck-sensor flag; constant 0 when the feature is compiled out

Behaviour:
- Reset (KEY[0]=0, asynchronous):
  - all synchroniser flops, debounce counters, LVL, RISE, REQ and STUCK go to 0;
  - the stuck counters also go to 0.
  - Release is synchronous to the next CLOCK_50 edge.
- Synchroniser: two flops per lane; sync = second flop.
- Debounce, per lane, with counter width $clog2(DEB_CYCLES):
  - sync == LVL: counter cleared.
  - sync != LVL and counter < DEB_CYCLES-1: counter increments.
  - sync != LVL and counter == DEB_CYCLES-1: LVL <= sync and the counter clears.
  - Any glitch back to the LVL value restarts the count from 0.
  - Latency from the SW edge to the LVL change is 2 + DEB_CYCLES cycles.
- RISE:
  - registered;
  - high for exactly the first cycle in which LVL is 1 after being 0;
  - never asserted on a 1->0 transition.
- REQ, per lane, registered:
  - REQ_next = RISE | (REQ & ~SERVE).
  - REQ rises the cycle after RISE.
  - SERVE clears REQ on the next edge.
  - RISE and SERVE in the same cycle: set wins, REQ stays/becomes 1.
  - SERVE while REQ=0: no effect.
  - If LVL is still 1 after SERVE, no new request until LVL falls and rises again (a served car is not re-requested).
- Lanes are fully independent; there are no cross-lane interactions.
- Reset mid-debounce: the partial count is lost; LVL restarts at 0. A switch held high across reset therefore produces a fresh RISE and REQ after 2 + DEB_CYCLES cycles.

Optional Feature:
- Macro: STUCK_DETECT_EN.
- Defined:
  - A per-lane 32-bit counter increments while LVL=1 and saturates at STUCK_CYCLES; it clears when LVL=0.
  - STUCK is set when the count reaches STUCK_CYCLES.
  - While STUCK=1, REQ is forced to 0 and RISE cannot set it.
  - STUCK clears, registered, on the cycle after LVL returns to 0.
- Undefined: there are no stuck counters, STUCK is tied to 2'b00, and REQ logic is exactly as above.

Decomposition:
- Shared package holds:
  - lane index constants LANE_N=0 and LANE_E=1, plus NUM_LANES=2;
  - default DEB_CYCLES and STUCK_CYCLES, both derived from the 50 MHz CNT_MAX constant used by the controller's 1 Hz divider.
- Sub-module lane_debouncer: synchroniser, debounce counter, LVL and RISE for one lane.
  - Instantiated twice through a generate loop.
  - The REQ latch and the stuck logic stay in the top.

Test Plan (DEB_CYCLES=4, STUCK_CYCLES=20 overrides):
- Reset then SW=2'b01 held -> LVL[0]=1 exactly 6 cycles after the SW edge, RISE[0] pulses 1 cycle, REQ[0]=1 on the following cycle; lane 1 remains 0.
- SW[1] glitches high for 3 cycles then low -> LVL[1], RISE[1] and REQ[1] stay 0 throughout.
- REQ[1]=1, SERVE[1] pulse while SW[1] still high -> REQ[1]=0 next cycle and stays 0; drop SW[1] for 6+ cycles and raise it again -> new RISE, REQ[1]=1.
- RISE[0] and SERVE[0] in the same cycle -> REQ[0]=1 after the edge.
- KEY[0] low mid-debounce, with the counter at 2 -> all outputs are 0 immediately; after release with SW held, LVL rises 6 cycles later.
- With STUCK_DETECT_EN: SW[0] held 30 cycles -> STUCK[0]=1 once the count hits 20, REQ[0] forced 0; SW[0] low -> STUCK[0]=0 the cycle after LVL[0] falls.
